// File: rtl/al_accel_pkg.sv
// Types and defaults shared by the accelerator cp-path blocks (feeder and cp unit).
package al_accel_pkg;

    localparam int DATA_W_DEF        = 8;
    localparam int LEN_W_DEF         = 8;
    // Both the cp unit and the feeder must agree on how long a clear lasts.
    localparam int CP_CLR_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/al_accel_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is readable the cycle after the push; full blocks pushes, empty blocks pops.
module al_accel_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/al_accel_cp_feeder.sv
// Buffers an upstream byte stream and feeds it to the cp unit as clear-then-stream frames.
// Latency: start->cp_clr 1 cycle; last cp_clr->first enb 2 cycles when data is buffered.
// Backpressure: s_ready = !full of the input FIFO; an empty FIFO mid-frame stalls enb.
module al_accel_cp_feeder
    import al_accel_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int CLR_CYCLES = CP_CLR_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cp_di,
    output logic              cp_clr,
    output logic              enb
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    feeder_state_t                  state;
    logic [LEN_W-1:0]               remaining;
    logic [CLR_W-1:0]               clr_cnt;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           fifo_pop;
    logic [DATA_W-1:0]              fifo_data;
    logic [$clog2(FIFO_DEPTH):0]    unused_fifo_count;

    assign s_ready  = !fifo_full;
    assign busy     = (state != ST_IDLE);
    // remaining is never zero while in STREAM, so occupancy alone gates the pop.
    assign fifo_pop = (state == ST_STREAM) && !fifo_empty;

    al_accel_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            clr_cnt   <= '0;
            cp_di     <= '0;
            cp_clr    <= 1'b0;
            enb       <= 1'b0;
            done      <= 1'b0;
        end else begin
            cp_clr <= 1'b0;
            enb    <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= frame_len;
                        clr_cnt   <= CLR_W'(CLR_CYCLES - 1);
                        cp_clr    <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == '0) begin
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                        cp_clr  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (fifo_pop) begin
                        cp_di     <= fifo_data;
                        enb       <= 1'b1;
                        remaining <= remaining - 1'b1;
                        // The last beat and the done pulse land in the same cycle.
                        if (remaining == LEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_al_accel_cp_feeder.sv
// Scoreboard bench for al_accel_cp_feeder: accepted bytes queue up as expected beats, frames are tracked by cycle offset from start.
module tb_al_accel_cp_feeder;

    localparam int CLR   = 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       start;
    logic [7:0] frame_len;
    logic       busy;
    logic       done;
    logic [7:0] cp_di;
    logic       cp_clr;
    logic       enb;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    al_accel_cp_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .start     (start),
        .frame_len (frame_len),
        .busy      (busy),
        .done      (done),
        .cp_di     (cp_di),
        .cp_clr    (cp_clr),
        .enb       (enb)
    );

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        else passes++;
    endfunction

    // Reference model: bytes accepted but not yet delivered, plus the active frame's progress.
    logic [7:0] exp_data [$];
    bit         started = 0;
    bit         rst_prev = 0;
    bit         act = 0;
    bit         prev_avail = 0;
    int         k = 0;
    int         len = 0;
    int         beats = 0;
    logic [7:0] last_di = 8'h00;

    initial begin
        bit         exp_clr, exp_enb, exp_done, exp_rdy, was_act;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                exp_data.delete();
                act        = 0;
                prev_avail = 0;
                last_di    = 8'h00;
                started    = 1;
            end
            if (started) begin
                exp_clr  = act && k >= 1 && k <= CLR;
                // A byte present in the previous stream cycle is popped then and beats now.
                exp_enb  = act && k >= CLR + 2 && beats < len && prev_avail;
                exp_done = act && ((len == 0 && k == CLR + 1) || (exp_enb && beats + 1 == len));
                chk("busy", busy, act);
                chk("cp_clr", cp_clr, exp_clr);
                chk("enb", enb, exp_enb);
                chk("done", done, exp_done);
                if (exp_enb) begin
                    if (exp_data.size() == 0) begin
                        chk("model_underflow", 1, 0);
                    end else begin
                        d = exp_data.pop_front();
                        chk("cp_di_beat", cp_di, d);
                        last_di = d;
                    end
                    beats++;
                end else begin
                    chk("cp_di_hold", cp_di, last_di);
                end
                exp_rdy = exp_data.size() < DEPTH;
                chk("s_ready", s_ready, exp_rdy);
                prev_avail = exp_data.size() > 0;
                was_act    = act;
                if (exp_done) act = 0;
                else if (act) k++;
                if (!reset) begin
                    if (s_valid && exp_rdy) exp_data.push_back(s_data);
                    if (start && !was_act) begin
                        act   = 1;
                        k     = 1;
                        len   = int'(frame_len);
                        beats = 0;
                    end
                end
            end
            rst_prev = reset;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        chk("push_timeout", s_ready, 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] l);
        start     = 1'b1;
        frame_len = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic basic_frame();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) push_byte(b[i]);
        pulse_start(8'd4);
        wait_idle();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        start     = 1'b0;
        frame_len = 8'h00;
        tick();
        do_reset();

        basic_frame();

        // Starved frame: one byte every third cycle.
        pulse_start(8'd3);
        for (int i = 0; i < 3; i++) begin
            repeat (2) tick();
            push_byte(8'hA0 + 8'(i));
        end
        wait_idle();
        tick();

        // Fill to full, hold a 17th byte, release it with a one-byte frame.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i + 1));
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (3) tick();
        chk("s_ready_full", s_ready, 0);
        pulse_start(8'd1);
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        chk("full_release", s_ready, 1);
        tick();
        s_valid = 1'b0;
        wait_idle();
        pulse_start(8'd16);
        wait_idle();
        tick();

        // Zero-length frame leaves buffered bytes in place.
        push_byte(8'h5A);
        push_byte(8'hA5);
        pulse_start(8'd0);
        wait_idle();
        tick();

        // Start while streaming is ignored.
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        pulse_start(8'd5);
        repeat (CLR + 2) tick();
        pulse_start(8'd9);
        wait_idle();
        tick();

        // Reset during the second beat of an 8-byte frame.
        for (int i = 0; i < 8; i++) push_byte(8'hD0 + 8'(i));
        pulse_start(8'd8);
        n = 0;
        while (!enb && n < 50) begin
            tick();
            n++;
        end
        chk("first_beat_timeout", enb, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        basic_frame();

        // Randomised traffic, including starts while busy.
        for (int i = 0; i < 400; i++) begin
            s_valid   = ($urandom_range(0, 9) < 6);
            s_data    = 8'($urandom);
            start     = ($urandom_range(0, 15) == 0);
            frame_len = 8'($urandom_range(0, 12));
            tick();
        end
        s_valid = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 300 && busy; i++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            tick();
        end
        s_valid = 1'b0;
        chk("drain_timeout", busy, 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
